// File: rtl/display_pkg.sv
`default_nettype none
// ============================================================================
// Module   : display_pkg
// Brief    : Shared state and source-owner encodings for the display path.
// Revision : 1.0 - initial release
// ============================================================================
package display_pkg;

    typedef enum logic [1:0] {
        FS_IDLE = 2'd0,
        FS_OWN  = 2'd1,
        FS_PEND = 2'd2
    } fs_state_t;

    localparam logic [1:0] SRC_NONE = 2'b00;
    localparam logic [1:0] SRC_UART = 2'b01;
    localparam logic [1:0] SRC_SPI  = 2'b10;

endpackage
`default_nettype wire

// File: rtl/frame_timeout.sv
`default_nettype none
// ============================================================================
// Module   : frame_timeout
// Brief    : Idle-cycle counter that flags expiry after TIMEOUT_CYCLES counts.
// Revision : 1.0 - initial release
// ============================================================================
module frame_timeout #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int                 c_CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(TIMEOUT_CYCLES);

    logic [c_CNT_W-1:0] r_cnt;

    // Saturates at the limit so a held enable never wraps back to zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (en && (r_cnt != c_LIMIT)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign expire = en && (r_cnt == c_LIMIT);

endmodule
`default_nettype wire

// File: rtl/frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : frame_scheduler
// Brief    : Per-frame arbitration of UART/SPI bytes onto the loader and
//            display buffer flip sequencing. Optional idle abort enabled by
//            FRAME_SCHEDULER_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module frame_scheduler
    import display_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] uart_data,
    input  logic       uart_valid,
    input  logic [7:0] spi_data,
    input  logic       spi_valid,
    output logic [7:0] ldata,
    output logic       lvalid,
    output logic       loader_rst,
    input  logic       loaded,
    output logic       ready,
    input  logic       frame_complete,
    output logic       mem_flip,
    output logic       frame_flipped,
    output logic [1:0] owner,
    output logic       dropped
);

    fs_state_t  r_state;
    logic [7:0] r_ldata;
    logic       r_lvalid;
    logic       r_loader_rst;
    logic       r_ready;
    logic       r_mem_flip;
    logic       r_flipped;
    logic [1:0] r_owner;
    logic       r_dropped;
    logic       r_prio_spi;

    logic w_win_uart;
    logic w_own_byte;
    logic w_other_byte;
    logic w_expire;

    // A contested claim goes to whichever source did not own the last frame.
    assign w_win_uart   = uart_valid && (!spi_valid || !r_prio_spi);
    assign w_own_byte   = (r_owner == SRC_UART) ? uart_valid : spi_valid;
    assign w_other_byte = (r_owner == SRC_UART) ? spi_valid  : uart_valid;

`ifdef FRAME_SCHEDULER_TIMEOUT_EN
    frame_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_frame_timeout (
        .clk    (clk),
        .rst    (rst),
        .clr    ((r_state != FS_OWN) || w_own_byte),
        .en     (r_state == FS_OWN),
        .expire (w_expire)
    );
`else
    assign w_expire = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= FS_IDLE;
            r_ldata      <= 8'h00;
            r_lvalid     <= 1'b0;
            r_loader_rst <= 1'b0;
            r_ready      <= 1'b1;
            r_mem_flip   <= 1'b0;
            r_flipped    <= 1'b0;
            r_owner      <= SRC_NONE;
            r_dropped    <= 1'b0;
            r_prio_spi   <= 1'b0;
        end else begin
            r_lvalid     <= 1'b0;
            r_loader_rst <= 1'b0;
            r_flipped    <= 1'b0;
            r_dropped    <= 1'b0;
            case (r_state)
                FS_IDLE: begin
                    if (uart_valid || spi_valid) begin
                        r_ldata    <= w_win_uart ? uart_data : spi_data;
                        r_lvalid   <= 1'b1;
                        r_owner    <= w_win_uart ? SRC_UART : SRC_SPI;
                        r_prio_spi <= w_win_uart;
                        r_dropped  <= uart_valid && spi_valid;
                        r_state    <= FS_OWN;
                    end
                end
                FS_OWN: begin
                    if (loaded) begin
                        if (w_own_byte) begin
                            r_ldata  <= (r_owner == SRC_UART) ? uart_data : spi_data;
                            r_lvalid <= 1'b1;
                        end
                        r_dropped <= w_other_byte;
                        r_owner   <= SRC_NONE;
                        r_ready   <= 1'b0;
                        r_state   <= FS_PEND;
                    end else if (w_expire) begin
                        // An abort discards anything arriving in the same cycle.
                        r_dropped    <= uart_valid || spi_valid;
                        r_loader_rst <= 1'b1;
                        r_owner      <= SRC_NONE;
                        r_state      <= FS_IDLE;
                    end else begin
                        if (w_own_byte) begin
                            r_ldata  <= (r_owner == SRC_UART) ? uart_data : spi_data;
                            r_lvalid <= 1'b1;
                        end
                        r_dropped <= w_other_byte;
                    end
                end
                FS_PEND: begin
                    r_dropped <= uart_valid || spi_valid;
                    if (frame_complete) begin
                        r_mem_flip <= ~r_mem_flip;
                        r_flipped  <= 1'b1;
                        r_ready    <= 1'b1;
                        r_state    <= FS_IDLE;
                    end
                end
                default: begin
                    r_state <= FS_IDLE;
                end
            endcase
        end
    end

    assign ldata         = r_ldata;
    assign lvalid        = r_lvalid;
    assign loader_rst    = r_loader_rst;
    assign ready         = r_ready;
    assign mem_flip      = r_mem_flip;
    assign frame_flipped = r_flipped;
    assign owner         = r_owner;
    assign dropped       = r_dropped;

endmodule
`default_nettype wire

// File: tb/tb_frame_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_frame_scheduler
// Brief    : Directed self-checking bench for frame_scheduler.
// Revision : 1.0 - initial release
// ============================================================================
module tb_frame_scheduler;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] uart_data, spi_data;
    logic       uart_valid, spi_valid;
    logic [7:0] ldata;
    logic       lvalid, loader_rst, loaded, ready, frame_complete;
    logic       mem_flip, frame_flipped, dropped;
    logic [1:0] owner;

    int total  = 0;
    int passed = 0;

    always #5 clk = ~clk;

    frame_scheduler #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .uart_data      (uart_data),
        .uart_valid     (uart_valid),
        .spi_data       (spi_data),
        .spi_valid      (spi_valid),
        .ldata          (ldata),
        .lvalid         (lvalid),
        .loader_rst     (loader_rst),
        .loaded         (loaded),
        .ready          (ready),
        .frame_complete (frame_complete),
        .mem_flip       (mem_flip),
        .frame_flipped  (frame_flipped),
        .owner          (owner),
        .dropped        (dropped)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        uart_valid = 0; spi_valid = 0; loaded = 0; frame_complete = 0;
    endtask

    task automatic test_reset();
        rst = 1; uart_data = 0; spi_data = 0; idle_inputs();
        #23;
        total++; if (ldata !== 8'h00) $display("FAIL reset_ldata got %h want 00", ldata); else passed++;
        total++; if (lvalid !== 1'b0) $display("FAIL reset_lvalid got %b want 0", lvalid); else passed++;
        total++; if (loader_rst !== 1'b0) $display("FAIL reset_loader_rst got %b want 0", loader_rst); else passed++;
        total++; if (ready !== 1'b1) $display("FAIL reset_ready got %b want 1", ready); else passed++;
        total++; if (mem_flip !== 1'b0) $display("FAIL reset_mem_flip got %b want 0", mem_flip); else passed++;
        total++; if (frame_flipped !== 1'b0) $display("FAIL reset_flipped got %b want 0", frame_flipped); else passed++;
        total++; if (owner !== 2'b00) $display("FAIL reset_owner got %b want 00", owner); else passed++;
        total++; if (dropped !== 1'b0) $display("FAIL reset_dropped got %b want 0", dropped); else passed++;
        @(negedge clk); rst = 0;
    endtask

    task automatic test_arbitration();
        uart_valid = 1; uart_data = 8'hAA; spi_valid = 1; spi_data = 8'hBB;
        tick(); idle_inputs();
        total++; if (ldata !== 8'hAA) $display("FAIL arb1_ldata got %h want aa", ldata); else passed++;
        total++; if (lvalid !== 1'b1) $display("FAIL arb1_lvalid got %b want 1", lvalid); else passed++;
        total++; if (owner !== 2'b01) $display("FAIL arb1_owner got %b want 01", owner); else passed++;
        total++; if (dropped !== 1'b1) $display("FAIL arb1_dropped got %b want 1", dropped); else passed++;
        loaded = 1; tick(); idle_inputs();
        total++; if (ready !== 1'b0) $display("FAIL arb_pend_ready got %b want 0", ready); else passed++;
        total++; if (owner !== 2'b00) $display("FAIL arb_pend_owner got %b want 00", owner); else passed++;
        frame_complete = 1; tick(); idle_inputs();
        total++; if (mem_flip !== 1'b1) $display("FAIL arb_flip got %b want 1", mem_flip); else passed++;
        total++; if (frame_flipped !== 1'b1) $display("FAIL arb_flipped got %b want 1", frame_flipped); else passed++;
        tick();
        total++; if (frame_flipped !== 1'b0) $display("FAIL arb_flipped_pulse got %b want 0", frame_flipped); else passed++;
        uart_valid = 1; uart_data = 8'h33; spi_valid = 1; spi_data = 8'h44;
        tick(); idle_inputs();
        total++; if (ldata !== 8'h44) $display("FAIL arb2_ldata got %h want 44", ldata); else passed++;
        total++; if (owner !== 2'b10) $display("FAIL arb2_owner got %b want 10", owner); else passed++;
        total++; if (dropped !== 1'b1) $display("FAIL arb2_dropped got %b want 1", dropped); else passed++;
        loaded = 1; tick(); idle_inputs();
        frame_complete = 1; tick(); idle_inputs();
        total++; if (mem_flip !== 1'b0) $display("FAIL arb2_flip got %b want 0", mem_flip); else passed++;
        tick();
    endtask

    task automatic test_claim_and_pend();
        uart_valid = 1; uart_data = 8'h11; tick(); idle_inputs();
        total++; if (ldata !== 8'h11) $display("FAIL claim_ldata got %h want 11", ldata); else passed++;
        total++; if (lvalid !== 1'b1) $display("FAIL claim_lvalid got %b want 1", lvalid); else passed++;
        total++; if (owner !== 2'b01) $display("FAIL claim_owner got %b want 01", owner); else passed++;
        total++; if (dropped !== 1'b0) $display("FAIL claim_dropped got %b want 0", dropped); else passed++;
        tick();
        total++; if (lvalid !== 1'b0) $display("FAIL claim_lvalid_low got %b want 0", lvalid); else passed++;
        spi_valid = 1; spi_data = 8'h22; tick(); idle_inputs();
        total++; if (dropped !== 1'b1) $display("FAIL nonowner_dropped got %b want 1", dropped); else passed++;
        total++; if (lvalid !== 1'b0) $display("FAIL nonowner_lvalid got %b want 0", lvalid); else passed++;
        total++; if (ldata !== 8'h11) $display("FAIL ldata_hold got %h want 11", ldata); else passed++;
        tick();
        total++; if (dropped !== 1'b0) $display("FAIL dropped_pulse got %b want 0", dropped); else passed++;
        loaded = 1; tick(); idle_inputs();
        total++; if (ready !== 1'b0) $display("FAIL pend_ready got %b want 0", ready); else passed++;
        uart_valid = 1; uart_data = 8'h5A; tick(); idle_inputs();
        total++; if (dropped !== 1'b1) $display("FAIL pend_dropped got %b want 1", dropped); else passed++;
        total++; if (lvalid !== 1'b0) $display("FAIL pend_lvalid got %b want 0", lvalid); else passed++;
        frame_complete = 1; tick(); idle_inputs();
        total++; if (mem_flip !== 1'b1) $display("FAIL pend_flip got %b want 1", mem_flip); else passed++;
        total++; if (frame_flipped !== 1'b1) $display("FAIL pend_flipped got %b want 1", frame_flipped); else passed++;
        total++; if (ready !== 1'b1) $display("FAIL pend_ready_back got %b want 1", ready); else passed++;
        tick();
    endtask

    task automatic test_simultaneous_loaded_fc();
        frame_complete = 1; loaded = 1; tick(); idle_inputs();
        total++; if (mem_flip !== 1'b1) $display("FAIL idle_fc_ignored got %b want 1", mem_flip); else passed++;
        total++; if (ready !== 1'b1) $display("FAIL idle_loaded_ignored got %b want 1", ready); else passed++;
        uart_valid = 1; uart_data = 8'h55; tick(); idle_inputs();
        loaded = 1; frame_complete = 1; tick(); idle_inputs();
        total++; if (ready !== 1'b0) $display("FAIL simul_ready got %b want 0", ready); else passed++;
        total++; if (mem_flip !== 1'b1) $display("FAIL simul_noflip got %b want 1", mem_flip); else passed++;
        total++; if (frame_flipped !== 1'b0) $display("FAIL simul_flipped got %b want 0", frame_flipped); else passed++;
        tick();
        frame_complete = 1; tick(); idle_inputs();
        total++; if (mem_flip !== 1'b0) $display("FAIL simul_flip got %b want 0", mem_flip); else passed++;
        total++; if (frame_flipped !== 1'b1) $display("FAIL simul_flipped2 got %b want 1", frame_flipped); else passed++;
        tick();
    endtask

`ifdef FRAME_SCHEDULER_TIMEOUT_EN
    task automatic test_timeout();
        spi_valid = 1; spi_data = 8'h66; tick(); idle_inputs();
        total++; if (owner !== 2'b10) $display("FAIL to_claim_owner got %b want 10", owner); else passed++;
        for (int i = 0; i < 16; i++) tick();
        total++; if (loader_rst !== 1'b0) $display("FAIL to_early got %b want 0", loader_rst); else passed++;
        total++; if (owner !== 2'b10) $display("FAIL to_early_owner got %b want 10", owner); else passed++;
        tick();
        total++; if (loader_rst !== 1'b1) $display("FAIL to_pulse got %b want 1", loader_rst); else passed++;
        total++; if (owner !== 2'b00) $display("FAIL to_owner got %b want 00", owner); else passed++;
        tick();
        total++; if (loader_rst !== 1'b0) $display("FAIL to_pulse_end got %b want 0", loader_rst); else passed++;
        spi_valid = 1; spi_data = 8'h77; tick(); idle_inputs();
        total++; if (owner !== 2'b10) $display("FAIL to_reclaim got %b want 10", owner); else passed++;
        total++; if (ldata !== 8'h77) $display("FAIL to_reclaim_data got %h want 77", ldata); else passed++;
        loaded = 1; tick(); idle_inputs();
        frame_complete = 1; tick(); idle_inputs();
        tick();
    endtask
`endif

    task automatic test_reset_midframe();
        logic exp_flip;
        exp_flip = ~mem_flip;
        uart_valid = 1; uart_data = 8'h88; tick(); idle_inputs();
        loaded = 1; tick(); idle_inputs();
        frame_complete = 1; tick(); idle_inputs();
        if (exp_flip == 1'b0) begin
            uart_valid = 1; uart_data = 8'h99; tick(); idle_inputs();
            loaded = 1; tick(); idle_inputs();
            frame_complete = 1; tick(); idle_inputs();
        end
        uart_valid = 1; uart_data = 8'h9A; tick(); idle_inputs();
        loaded = 1; tick(); idle_inputs();
        total++; if (mem_flip !== 1'b1) $display("FAIL mid_pre_flip got %b want 1", mem_flip); else passed++;
        total++; if (ready !== 1'b0) $display("FAIL mid_pre_ready got %b want 0", ready); else passed++;
        #2 rst = 1; #1;
        total++; if (mem_flip !== 1'b0) $display("FAIL mid_rst_flip got %b want 0", mem_flip); else passed++;
        total++; if (ready !== 1'b1) $display("FAIL mid_rst_ready got %b want 1", ready); else passed++;
        total++; if (owner !== 2'b00) $display("FAIL mid_rst_owner got %b want 00", owner); else passed++;
        @(negedge clk); rst = 0;
        tick();
    endtask

    initial begin
        test_reset();
        test_arbitration();
        test_claim_and_pend();
        test_simultaneous_loaded_fc();
`ifdef FRAME_SCHEDULER_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_midframe();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/frame_scheduler.md
# frame_scheduler

Arbitrates the UART and SPI byte receivers onto the single `data_loader` byte input, and sequences the double-buffered `display_memory` flip against the `display_driver` frame boundary. Ownership is granted per frame: a source that starts a frame keeps the loader until the frame is loaded or aborted. The block sits between the receivers and `data_loader`. It owns the `ready`, `mem_flip` and `frame_flipped` signals for the display top level.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 1000000 — idle cycles allowed between owner bytes before the frame is aborted.

Ports. One clock; reset is asynchronous and active-high.
- `clk`  in  1  system clock (PLL output)
- `rst`  in  1  asynchronous, active-high reset
- `uart_data`  in  8  byte from `uart_rx`
- `uart_valid`  in  1  single-cycle strobe qualifying `uart_data`
- `spi_data`  in  8  byte from the SPI receiver
- `spi_valid`  in  1  single-cycle strobe qualifying `spi_data`
- `ldata`  out  8  byte to `data_loader.idata`
- `lvalid`  out  1  strobe to `data_loader.ivalid`
- `loader_rst`  out  1  one-cycle pulse that resynchronises `data_loader` after an abort
- `loaded`  in  1  `data_loader` frame-loaded pulse
- `ready`  out  1  to `data_loader.ready`
- `frame_complete`  in  1  `display_driver` end-of-frame pulse
- `mem_flip`  out  1  buffer select to `display_memory`
- `frame_flipped`  out  1  one-cycle pulse when a flip occurs
- `owner`  out  2  current owner: 00 none, 01 UART, 10 SPI
- `dropped`  out  1  one-cycle pulse when any input byte is discarded

## Operation
- States: IDLE, OWN, PEND.
- IDLE:
  - `ready`=1, `owner`=00.
  - The first valid byte claims ownership; that byte is forwarded. Transition to OWN.
  - If both sources are valid in the same cycle, the source that did not own the previous frame wins. After reset, UART wins. The losing byte is dropped.
- OWN:
  - `ready`=1.
  - Owner bytes are forwarded.
  - Non-owner bytes are dropped (`dropped` pulses).
  - `loaded`=1 → PEND, owner cleared.
- PEND:
  - `ready`=0; all input bytes are dropped.
  - `frame_complete`=1 → toggle `mem_flip`, pulse `frame_flipped`, go to IDLE.
- Simultaneous `loaded` and `frame_complete` while in OWN: go to PEND only. The flip waits for the next `frame_complete`.
- `frame_complete` in IDLE or OWN: ignored.
- `loaded` outside OWN: ignored.
- `dropped` pulses once per cycle in which at least one byte is discarded. Both sources discarded in one cycle still gives a single pulse.

## Timing
- Reset values:
  - state IDLE
  - `ldata`=0, `lvalid`=0, `loader_rst`=0
  - `ready`=1
  - `mem_flip`=0, `frame_flipped`=0
  - `owner`=00, `dropped`=0
  - round-robin priority: UART
- Forward latency: input strobe in cycle N → `ldata`/`lvalid` registered in cycle N+1. `ldata` holds its value when `lvalid`=0.
- `owner` and `ready` are registered and update the cycle after the triggering event.
- Flip: `frame_complete` in cycle N while in PEND → `mem_flip` toggled, `frame_flipped`=1 and `ready`=1 all in cycle N+1.
- `dropped` appears in cycle N+1 for a drop in cycle N.
- Reset asserted mid-frame: all outputs return to reset values immediately. `mem_flip` returns to 0.

## Configuration
- Macro: `FRAME_SCHEDULER_TIMEOUT_EN`.
- Defined:
  - An idle counter of width `$clog2(TIMEOUT_CYCLES+1)` runs in OWN. It clears on each owner byte.
  - When the count reaches `TIMEOUT_CYCLES`: pulse `loader_rst` in the next cycle, clear owner, go to IDLE.
  - The aborted source counts as previous owner for arbitration.
  - If `loaded` and the timeout occur in the same cycle, `loaded` wins.
- Undefined:
  - No counter; OWN is left only via `loaded`.
  - `loader_rst` is tied to 0.

## Structure
- `display_pkg` holds:
  - the state enum (`FS_IDLE`, `FS_OWN`, `FS_PEND`)
  - owner encodings (`SRC_NONE`, `SRC_UART`, `SRC_SPI`)
- Sub-module `frame_timeout`:
  - the idle counter with clear/enable/expire
  - instantiated only under `FRAME_SCHEDULER_TIMEOUT_EN`

## Test plan
- UART byte 0x11 in IDLE → `ldata`=0x11, `lvalid`=1 next cycle, `owner`=01. An SPI byte 0x22 two cycles later → `dropped`=1, no `lvalid`.
- Both sources valid in cycle 0 after reset → UART (0xAA) forwarded, SPI dropped. Finish the frame and flip, then repeat the simultaneous bytes → SPI wins.
- `loaded` pulse in OWN → `ready`=0 next cycle; bytes in PEND dropped. `frame_complete` → `mem_flip` 0→1, `frame_flipped` single pulse, `ready`=1.
- `loaded` and `frame_complete` in the same cycle → no flip. The next `frame_complete` → flip.
- With `FRAME_SCHEDULER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=16: owner silent for 16 cycles → `loader_rst` pulse, `owner`=00. The next SPI byte claims ownership.
- Reset asserted in PEND with `mem_flip`=1 → `mem_flip`=0, `ready`=1, `owner`=00 asynchronously.
